sm3_msg_expand: RTL and testbench

SM3 message-expansion stage. Takes one padded 512-bit message block and streams the 64 expanded word pairs (W_j, W'_j), one pair per transfer, into the SM3 compression-round datapath, where its 32-bit modular adders consume them. It generates W16..W67 on the fly from a 16-word sliding window, with no 68-word buffer, and supports downstream backpressure.

---
 rtl/sm3_msg_expand.sv | 92 +++++++++
 tb/tb_sm3_msg_expand.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_msg_expand.sv
// SM3 message expansion: streams (W_j, W'_j) for j = 0..63 from a 16-word
// sliding window, generating W16..W67 on the fly, with downstream backpressure.
module sm3_msg_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block,
  input  logic         ready,
  output logic         busy,
  output logic         w_valid,
  output logic [5:0]   w_idx,
  output logic [31:0]  w,
  output logic [31:0]  w1,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_win [16];
  logic [5:0]  r_idx;

  logic        w_load;
  logic        w_xfer;
  logic [31:0] w_p1_in;
  logic [31:0] w_new;
  logic [31:0] w_shift   [16];
  logic [31:0] w_blk_word[16];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  assign w_load  = (r_state == S_IDLE) && start;
  assign w_xfer  = (r_state == S_RUN) && ready;
  assign w_p1_in = r_win[0] ^ r_win[7] ^ rotl(r_win[13], 15);
  assign w_new   = p1(w_p1_in) ^ rotl(r_win[3], 7) ^ r_win[10];

  // Each slot takes its big-endian block word on load, else its upper neighbour.
  for (genvar gi = 0; gi < 16; gi++) begin : g_win
    assign w_blk_word[gi] = block[511 - 32*gi -: 32];
    if (gi == 15) begin : g_top
      assign w_shift[gi] = w_new;
    end else begin : g_mid
      assign w_shift[gi] = r_win[gi + 1];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (ready && (r_idx == 6'd63)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 6'd0;
      for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_idx <= 6'd0;
        for (int i = 0; i < 16; i++) r_win[i] <= w_blk_word[i];
      end else if (w_xfer) begin
        r_idx <= r_idx + 6'd1;
        for (int i = 0; i < 16; i++) r_win[i] <= w_shift[i];
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign w_valid = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign w_idx   = r_idx;
  assign w       = r_win[0];
  assign w1      = r_win[0] ^ r_win[4];

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Directed bench for sm3_msg_expand: "abc" reference vector, stalls, ignored
// starts, mid-run reset and back-to-back blocks, against a 68-word reference model.
module tb_sm3_msg_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [511:0] block = '0;
  logic         ready = 1'b1;
  logic         busy;
  logic         w_valid;
  logic [5:0]   w_idx;
  logic [31:0]  w;
  logic [31:0]  w1;
  logic         done;

  sm3_msg_expand dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .block   (block),
    .ready   (ready),
    .busy    (busy),
    .w_valid (w_valid),
    .w_idx   (w_idx),
    .w       (w),
    .w1      (w1),
    .done    (done)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] ALT = {16{32'hdeadbeef}};
  localparam logic [511:0] B2  = {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
                                  32'h0f1e2d3c, 32'h4b5a6978, 32'h8796a5b4, 32'hc3d2e1f0,
                                  32'h13579bdf, 32'h2468ace0, 32'hcafebabe, 32'h00ff00ff,
                                  32'h80000000, 32'h00000001, 32'h55aa55aa, 32'h0badf00d};

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w [68];
  logic [31:0] cap_w [64];
  logic [31:0] cap_w1[64];
  int npairs, done_cyc, first_cyc, seq_bad, hold_bad;
  bit aborted;

  function automatic logic [31:0] rl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  // Textbook array form of the expansion, indexed by absolute word number.
  task automatic build_model(input logic [511:0] b);
    logic [31:0] t;
    for (int j = 0; j < 16; j++) exp_w[j] = b[511 - 32*j -: 32];
    for (int j = 16; j < 68; j++) begin
      t = exp_w[j-16] ^ exp_w[j-9] ^ rl(exp_w[j-3], 15);
      exp_w[j] = (t ^ rl(t, 15) ^ rl(t, 23)) ^ rl(exp_w[j-13], 7) ^ exp_w[j-6];
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts one block and records what the DUT presents; returns in the done cycle.
  task automatic drive_stream(input logic [511:0] blk, input int stall5, input bit stall63,
                              input bit poke10, input int abort_at);
    logic [5:0]  h_idx;
    logic [31:0] h_w, h_w1;
    bit held, s63;
    int s5, exp_next;
    npairs = 0; done_cyc = -1; first_cyc = -1; seq_bad = 0; hold_bad = 0; aborted = 0;
    held = 0; s63 = 0; s5 = 0; exp_next = 0; h_idx = '0; h_w = '0; h_w1 = '0;
    for (int j = 0; j < 64; j++) begin
      cap_w[j] = 'x;
      cap_w1[j] = 'x;
    end
    block = blk; start = 1'b1; ready = 1'b1;
    step;
    start = 1'b0; block = ALT;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      if (held) begin
        if (w_idx !== h_idx || w !== h_w || w1 !== h_w1) hold_bad++;
        held = 0;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      start = 1'b0; block = ALT;
      if (w_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (abort_at >= 0 && int'(w_idx) == abort_at) begin
          rst = 1'b1;
          step;
          rst = 1'b0;
          aborted = 1;
          return;
        end
        ready = 1'b1;
        if (w_idx == 6'd5 && s5 < stall5) begin
          ready = 1'b0; s5++;
        end else if (w_idx == 6'd63 && stall63 && !s63) begin
          ready = 1'b0; s63 = 1;
        end
        if (poke10 && w_idx == 6'd10) start = 1'b1;
        if (ready) begin
          if (int'(w_idx) != exp_next) seq_bad++;
          cap_w[w_idx] = w;
          cap_w1[w_idx] = w1;
          npairs++;
          exp_next++;
        end else begin
          held = 1; h_idx = w_idx; h_w = w; h_w1 = w1;
        end
      end else begin
        seq_bad++;
      end
      step;
    end
    ready = 1'b1; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    rst = 1'b0;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_w_valid got %b want 0", w_valid); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (w_idx !== 6'd0)   begin errors++; $display("FAIL reset_w_idx got %0d want 0", w_idx); end
    checks++; if (w !== 32'd0)      begin errors++; $display("FAIL reset_w got %h want 0", w); end
    checks++; if (w1 !== 32'd0)     begin errors++; $display("FAIL reset_w1 got %h want 0", w1); end
    $display("reset: outputs sampled after release");
  endtask

  task automatic test_abc;
    logic [31:0] hand16 [4];
    hand16[0] = 32'h9092e200; hand16[1] = 32'h00000000;
    hand16[2] = 32'h000c0606; hand16[3] = 32'h719c70ed;
    build_model(ABC);
    drive_stream(ABC, 0, 0, 0, -1);
    checks++; if (first_cyc != 1)  begin errors++; $display("FAIL abc_first_cycle got %0d want 1", first_cyc); end
    checks++; if (done_cyc != 65)  begin errors++; $display("FAIL abc_done_cycle got %0d want 65", done_cyc); end
    checks++; if (npairs != 64 || seq_bad != 0) begin
      errors++; $display("FAIL abc_sequence pairs %0d gaps %0d want 64/0", npairs, seq_bad);
    end
    checks++; if (busy !== 1'b1 || w_valid !== 1'b0) begin
      errors++; $display("FAIL abc_done_flags busy %b w_valid %b want 1/0", busy, w_valid);
    end
    checks++; if (cap_w[0] !== 32'h61626380)   begin errors++; $display("FAIL abc_w0 got %h want 61626380", cap_w[0]); end
    checks++; if (cap_w1[0] !== 32'h61626380)  begin errors++; $display("FAIL abc_w1_0 got %h want 61626380", cap_w1[0]); end
    checks++; if (cap_w1[12] !== 32'h9092e200) begin errors++; $display("FAIL abc_w1_12 got %h want 9092e200", cap_w1[12]); end
    checks++; if (cap_w1[15] !== 32'h719c70f5) begin errors++; $display("FAIL abc_w1_15 got %h want 719c70f5", cap_w1[15]); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap_w[16+k] !== hand16[k]) begin
        errors++; $display("FAIL abc_w%0d got %h want %h", 16+k, cap_w[16+k], hand16[k]);
      end
    end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (cap_w[j] !== exp_w[j] || cap_w1[j] !== (exp_w[j] ^ exp_w[j+4])) begin
        errors++; $display("FAIL abc_pair%0d got %h/%h want %h/%h", j, cap_w[j], cap_w1[j], exp_w[j], exp_w[j] ^ exp_w[j+4]);
      end
    end
    step;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abc_idle_after busy %b done %b want 0/0", busy, done);
    end
    $display("abc block: %0d pairs, done at cycle %0d", npairs, done_cyc);
  endtask

  task automatic test_backpressure;
    build_model(ABC);
    drive_stream(ABC, 3, 1, 0, -1);
    checks++; if (done_cyc != 69) begin errors++; $display("FAIL bp_done_cycle got %0d want 69", done_cyc); end
    checks++; if (hold_bad != 0)  begin errors++; $display("FAIL bp_hold_stable got %0d changes want 0", hold_bad); end
    checks++; if (npairs != 64 || seq_bad != 0) begin
      errors++; $display("FAIL bp_sequence pairs %0d gaps %0d want 64/0", npairs, seq_bad);
    end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (cap_w[j] !== exp_w[j] || cap_w1[j] !== (exp_w[j] ^ exp_w[j+4])) begin
        errors++; $display("FAIL bp_pair%0d got %h/%h want %h/%h", j, cap_w[j], cap_w1[j], exp_w[j], exp_w[j] ^ exp_w[j+4]);
      end
    end
    step;
    $display("backpressure block: %0d pairs, done at cycle %0d", npairs, done_cyc);
  endtask

  task automatic test_start_busy;
    int bad;
    build_model(ABC);
    drive_stream(ABC, 0, 0, 1, -1);
    checks++; if (done_cyc != 65) begin errors++; $display("FAIL sb_done_cycle got %0d want 65", done_cyc); end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (cap_w[j] !== exp_w[j] || cap_w1[j] !== (exp_w[j] ^ exp_w[j+4])) begin
        errors++; $display("FAIL sb_pair%0d got %h/%h want %h/%h", j, cap_w[j], cap_w1[j], exp_w[j], exp_w[j] ^ exp_w[j+4]);
      end
    end
    start = 1'b1; block = ALT;
    step;
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy !== 1'b0 || w_valid !== 1'b0) bad++;
      step;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL sb_no_second_run got %0d busy cycles want 0", bad); end
    $display("start-while-busy block: %0d pairs, done at cycle %0d", npairs, done_cyc);
  endtask

  task automatic test_reset_mid;
    int bad;
    build_model(ABC);
    drive_stream(ABC, 0, 0, 0, 30);
    checks++; if (aborted != 1) begin errors++; $display("FAIL rm_reached_idx30 got %0d want 1", aborted); end
    checks++; if (w_valid !== 1'b0 || busy !== 1'b0 || w_idx !== 6'd0 || w !== 32'd0 || w1 !== 32'd0) begin
      errors++; $display("FAIL rm_after_reset valid %b busy %b idx %0d w %h w1 %h want 0", w_valid, busy, w_idx, w, w1);
    end
    bad = 0;
    for (int k = 0; k < 70; k++) begin
      if (done !== 1'b0 || w_valid !== 1'b0) bad++;
      step;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rm_no_done got %0d active cycles want 0", bad); end
    drive_stream(ABC, 0, 0, 0, -1);
    checks++; if (done_cyc != 65) begin errors++; $display("FAIL rm_restart_done got %0d want 65", done_cyc); end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (cap_w[j] !== exp_w[j] || cap_w1[j] !== (exp_w[j] ^ exp_w[j+4])) begin
        errors++; $display("FAIL rm_pair%0d got %h/%h want %h/%h", j, cap_w[j], cap_w1[j], exp_w[j], exp_w[j] ^ exp_w[j+4]);
      end
    end
    step;
    $display("reset-mid block: aborted at idx 30, restart done at cycle %0d", done_cyc);
  endtask

  task automatic test_back_to_back;
    build_model(ABC);
    drive_stream(ABC, 0, 0, 0, -1);
    checks++; if (done_cyc != 65) begin errors++; $display("FAIL b2b_first_done got %0d want 65", done_cyc); end
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap busy %b want 0", busy); end
    build_model(B2);
    drive_stream(B2, 0, 0, 0, -1);
    checks++; if (first_cyc != 1) begin errors++; $display("FAIL b2b_second_first got %0d want 1", first_cyc); end
    checks++; if (cap_w[0] !== 32'h01234567) begin errors++; $display("FAIL b2b_w0 got %h want 01234567", cap_w[0]); end
    checks++; if (done_cyc != 65) begin errors++; $display("FAIL b2b_second_done got %0d want 65", done_cyc); end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (cap_w[j] !== exp_w[j] || cap_w1[j] !== (exp_w[j] ^ exp_w[j+4])) begin
        errors++; $display("FAIL b2b_pair%0d got %h/%h want %h/%h", j, cap_w[j], cap_w1[j], exp_w[j], exp_w[j] ^ exp_w[j+4]);
      end
    end
    step;
    $display("back-to-back second block: %0d pairs, done at cycle %0d", npairs, done_cyc);
  endtask

  initial begin
    test_reset;
    test_abc;
    test_backpressure;
    test_start_busy;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
